// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem requests, IF/ID register.
// Optional stall-cycle counter enabled with `define FETCH_STAGE_PERF_EN.
module fetch_stage #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_write,
  input  logic               ifid_write,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [3:0]         if_id_rs,
  output logic [3:0]         if_id_rt
`ifdef FETCH_STAGE_PERF_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;

  state_t               r_state;
  logic [PC_W-1:0]      r_pc;
  logic                 r_req;
  logic [INSTR_W-1:0]   r_buf;
  logic                 r_ifid_valid;
  logic [INSTR_W-1:0]   r_ifid_instr;
  logic [PC_W-1:0]      r_ifid_pc;

  logic                 w_advance;
  logic [PC_W-1:0]      w_pc_inc;
  logic                 w_deliver;
  logic [INSTR_W-1:0]   w_word;

  assign w_advance = pc_write & ifid_write;
  assign w_pc_inc  = r_pc + PC_W'(1);

  // A word reaches IF/ID either straight off the bus or from the hold buffer.
  always_comb begin
    w_deliver = 1'b0;
    w_word    = r_buf;
    if (!branch_taken && w_advance) begin
      if (r_state == WAIT && imem_valid) begin
        w_deliver = 1'b1;
        w_word    = imem_rdata;
      end else if (r_state == HOLD) begin
        w_deliver = 1'b1;
      end
    end
  end

  // Fetch FSM; redirect wins in every state, r_req tracks entry into ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ISSUE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b1;
      r_buf   <= '0;
    end else begin
      case (r_state)
        ISSUE: begin
          r_req <= 1'b0;
          if (branch_taken) begin
            r_pc    <= branch_target;
            r_state <= DROP;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (branch_taken) begin
            r_pc <= branch_target;
            if (imem_valid) begin
              r_state <= ISSUE;
              r_req   <= 1'b1;
            end else begin
              r_state <= DROP;
            end
          end else if (imem_valid) begin
            if (w_advance) begin
              r_pc    <= w_pc_inc;
              r_state <= ISSUE;
              r_req   <= 1'b1;
            end else begin
              r_buf   <= imem_rdata;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (branch_taken) begin
            r_pc    <= branch_target;
            r_state <= ISSUE;
            r_req   <= 1'b1;
          end else if (w_advance) begin
            r_pc    <= w_pc_inc;
            r_state <= ISSUE;
            r_req   <= 1'b1;
          end
        end
        DROP: begin
          if (branch_taken) begin
            r_pc <= branch_target;
          end
          // A response landing together with a redirect still drains the stale request.
          if (imem_valid) begin
            r_state <= ISSUE;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= ISSUE;
          r_req   <= 1'b1;
        end
      endcase
    end
  end

  // IF/ID: flush on redirect, hold when stalled, otherwise load a word or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
    end else if (branch_taken) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
    end else if (ifid_write) begin
      if (w_deliver) begin
        r_ifid_valid <= 1'b1;
        r_ifid_instr <= w_word;
        r_ifid_pc    <= r_pc;
      end else begin
        r_ifid_valid <= 1'b0;
        r_ifid_instr <= '0;
      end
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign if_id_valid = r_ifid_valid;
  assign if_id_instr = r_ifid_instr;
  assign if_id_pc    = r_ifid_pc;
  assign if_id_rs    = r_ifid_instr[7:4];
  assign if_id_rt    = r_ifid_instr[3:0];

`ifdef FETCH_STAGE_PERF_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles spent holding a word or with IF/ID frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == HOLD || !ifid_write) && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule
